// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: issues sram-like fetches for the current PC, tracks
// outstanding requests and buffers returned words with their PCs for decode.
module inst_fetch_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] pc,
    output logic        pc_adv,
    input  logic        flush,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_adel
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("RESET_PC must be word aligned");
    end

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        adel;
    } entry_t;

    entry_t        q_mem   [DEPTH];
    logic   [31:0] tag_mem [DEPTH];
    logic [PW-1:0] q_wp, q_rp, t_wp, t_rp;
    logic [CW-1:0] count, pend, drop;

    logic          space, aligned, accept, adel_push;
    logic          resp_push, resp_drop, push, pop;
    logic [CW:0]   occ;
    entry_t        wr_entry;
    entry_t        head;

    assign occ       = {1'b0, count} + {1'b0, pend};
    assign space     = occ < (CW + 1)'(DEPTH);
    assign aligned   = (pc[1:0] == 2'b00);

    // Gated by resetn so the handshake outputs are quiet while reset is held.
    assign inst_req  = resetn & space & ~flush & aligned & (drop == '0);
    assign inst_addr = pc;
    assign accept    = inst_req & inst_addr_ok;
    assign adel_push = resetn & ~aligned & space & (pend == '0) & (drop == '0) & ~flush;
    assign pc_adv    = accept | adel_push;

    assign resp_drop = inst_data_ok & (drop != '0);
    assign resp_push = inst_data_ok & (drop == '0);
    assign push      = resp_push | adel_push;
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_entry = '{inst: 32'h0, pc: pc, adel: 1'b1};
        if (resp_push) begin
            wr_entry = '{inst: inst_rdata, pc: tag_mem[t_rp], adel: 1'b0};
        end
    end

    assign head     = q_mem[q_rp];
    assign out_inst = head.inst;
    assign out_pc   = head.pc;
    assign out_adel = head.adel;

    // Tag store holds PCs of requests in flight; pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[t_wp] <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            // NOTE: queue storage is reset because out_* come straight from the head
            // entry and must read 0 after reset; the tag store needs no reset.
            for (int i = 0; i < DEPTH; i++) begin
                q_mem[i] <= '0;
            end
            q_wp  <= '0;
            q_rp  <= '0;
            t_wp  <= '0;
            t_rp  <= '0;
            count <= '0;
            pend  <= '0;
            drop  <= '0;
        end else if (flush) begin
            // Every in-flight response, minus one returning right now, must be eaten later.
            q_wp  <= '0;
            q_rp  <= '0;
            t_wp  <= '0;
            t_rp  <= '0;
            count <= '0;
            pend  <= '0;
            drop  <= drop + pend - CW'(inst_data_ok);
        end else begin
            if (accept) begin
                t_wp <= t_wp + 1'b1;
            end
            if (resp_push) begin
                t_rp <= t_rp + 1'b1;
            end
            if (push) begin
                q_mem[q_wp] <= wr_entry;
                q_wp        <= q_wp + 1'b1;
            end
            if (pop) begin
                q_rp <= q_rp + 1'b1;
            end
            if (resp_drop) begin
                drop <= drop - 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
            pend  <= pend + CW'(accept) - CW'(resp_push);
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: directed phases push expected entries,
// an independent monitor pops and compares whenever decode consumes the head.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] pc;
    logic        pc_adv;
    logic        flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_adel;

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(2), .RESET_PC(32'hbfc0_0000)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .pc           (pc),
        .pc_adv       (pc_adv),
        .flush        (flush),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_rdata   (inst_rdata),
        .inst_data_ok (inst_data_ok),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_inst     (out_inst),
        .out_pc       (out_pc),
        .out_adel     (out_adel)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_acc    = 0;
    bit          mem_hold = 1'b0;
    bit          adv_seen = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic expect_entry(input logic [31:0] epc, input logic [31:0] einst, input logic eadel);
        exp_t e;
        e.pc   = epc;
        e.inst = einst;
        e.adel = eadel;
        sb.push_back(e);
    endtask

    // Memory image: word at bfc0_0000 + 4k is 3c08_0000 + k + 1.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h3c08_0000 + ((addr - 32'hbfc0_0000) >> 2) + 32'd1;
    endfunction

    // Mid-cycle sample of this cycle's handshakes.
    task automatic sample();
        @(negedge clk);
        adv_seen = pc_adv;
        if (inst_req && inst_addr_ok) begin
            check("inst_addr", inst_addr, pc);
            check("pc_adv_on_accept", {31'h0, pc_adv}, 32'h1);
            mem_q.push_back(inst_addr);
            n_acc++;
        end
    endtask

    // Clock edge: PC register update, end of a one-cycle flush, memory response.
    task automatic adv();
        @(posedge clk);
        #1;
        if (flush) begin
            flush = 1'b0;
            pc    = redirect_pc;
        end else if (adv_seen) begin
            pc = pc + 32'd4;
        end
        if (!mem_hold && mem_q.size() > 0) begin
            inst_data_ok = 1'b1;
            inst_rdata   = mem_word(mem_q.pop_front());
        end else begin
            inst_data_ok = 1'b0;
            inst_rdata   = 32'hdead_beef;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            sample();
            adv();
        end
    endtask

    task automatic drain(input string name);
        cyc(6);
        sample();
        check({name, "_drained_valid"}, {31'h0, out_valid}, 32'h0);
        check({name, "_sb_empty"}, sb.size(), 32'h0);
        adv();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: got pc %h inst %h, expected no entry", out_pc, out_inst);
                end else begin
                    e = sb.pop_front();
                    check("out_pc", out_pc, e.pc);
                    check("out_inst", out_inst, e.inst);
                    check("out_adel", {31'h0, out_adel}, {31'h0, e.adel});
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int acc0;
        resetn       = 1'b0;
        pc           = 32'hbfc0_0000;
        flush        = 1'b0;
        inst_addr_ok = 1'b1;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        out_ready    = 1'b0;

        // Reset values.
        @(negedge clk);
        check("rst_inst_req", {31'h0, inst_req}, 32'h0);
        check("rst_pc_adv", {31'h0, pc_adv}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_adel", {31'h0, out_adel}, 32'h0);
        @(posedge clk);
        #1;
        resetn    = 1'b1;
        out_ready = 1'b1;

        // Streaming fetch from the boot vector.
        expect_entry(32'hbfc0_0000, 32'h3c08_0001, 1'b0);
        expect_entry(32'hbfc0_0004, 32'h3c08_0002, 1'b0);
        expect_entry(32'hbfc0_0008, 32'h3c08_0003, 1'b0);
        expect_entry(32'hbfc0_000c, 32'h3c08_0004, 1'b0);
        expect_entry(32'hbfc0_0010, 32'h3c08_0005, 1'b0);
        expect_entry(32'hbfc0_0014, 32'h3c08_0006, 1'b0);
        sample();
        check("boot_req", {31'h0, inst_req}, 32'h1);
        check("boot_addr", inst_addr, 32'hbfc0_0000);
        adv();
        sample();
        check("lat_c1_valid", {31'h0, out_valid}, 32'h0);
        adv();
        sample();
        check("lat_c2_valid", {31'h0, out_valid}, 32'h1);
        check("lat_c2_pc", out_pc, 32'hbfc0_0000);
        check("lat_c2_inst", out_inst, 32'h3c08_0001);
        adv();
        for (int i = 0; i < 40 && n_acc < 6; i++) cyc(1);
        check("stream_accepts", n_acc, 32'd6);
        inst_addr_ok = 1'b0;
        drain("stream");

        // Decode stalled: queue fills to two, then resumes after the first pop.
        out_ready    = 1'b0;
        inst_addr_ok = 1'b1;
        acc0         = n_acc;
        expect_entry(32'hbfc0_0018, 32'h3c08_0007, 1'b0);
        expect_entry(32'hbfc0_001c, 32'h3c08_0008, 1'b0);
        cyc(3);
        sample();
        check("full_valid", {31'h0, out_valid}, 32'h1);
        check("full_req", {31'h0, inst_req}, 32'h0);
        check("full_accepts", n_acc - acc0, 32'd2);
        adv();
        sample();
        check("full_req_hold", {31'h0, inst_req}, 32'h0);
        adv();
        out_ready = 1'b1;
        sample();
        check("pop_cycle_req", {31'h0, inst_req}, 32'h0);
        adv();
        inst_addr_ok = 1'b0;
        sample();
        check("after_pop_req", {31'h0, inst_req}, 32'h1);
        adv();
        drain("stall");

        // Flush with two requests outstanding; both responses must be dropped.
        mem_hold     = 1'b1;
        inst_addr_ok = 1'b1;
        redirect_pc  = 32'hbfc0_0100;
        cyc(2);
        flush = 1'b1;
        sample();
        check("flush_req", {31'h0, inst_req}, 32'h0);
        check("flush_valid", {31'h0, out_valid}, 32'h0);
        adv();
        mem_hold = 1'b0;
        sample();
        check("drop2_req", {31'h0, inst_req}, 32'h0);
        adv();
        sample();
        check("drop2_data_req", {31'h0, inst_req}, 32'h0);
        check("drop2_data_valid", {31'h0, out_valid}, 32'h0);
        adv();
        sample();
        check("drop1_data_req", {31'h0, inst_req}, 32'h0);
        check("drop1_data_valid", {31'h0, out_valid}, 32'h0);
        adv();
        expect_entry(32'hbfc0_0100, 32'h3c08_0041, 1'b0);
        sample();
        check("post_drop_req", {31'h0, inst_req}, 32'h1);
        check("post_drop_addr", inst_addr, 32'hbfc0_0100);
        adv();
        inst_addr_ok = 1'b0;
        drain("flush");

        // Misaligned PC becomes a single AdEL entry without a memory request.
        out_ready    = 1'b0;
        inst_addr_ok = 1'b1;
        pc           = 32'hbfc0_0002;
        expect_entry(32'hbfc0_0002, 32'h0, 1'b1);
        sample();
        check("adel_req", {31'h0, inst_req}, 32'h0);
        check("adel_pc_adv", {31'h0, pc_adv}, 32'h1);
        adv();
        pc           = 32'hbfc0_0300;
        inst_addr_ok = 1'b0;
        sample();
        check("adel_valid", {31'h0, out_valid}, 32'h1);
        check("adel_flag", {31'h0, out_adel}, 32'h1);
        check("adel_inst", out_inst, 32'h0);
        check("adel_pc", out_pc, 32'hbfc0_0002);
        adv();
        out_ready = 1'b1;
        cyc(1);
        sample();
        check("adel_single", {31'h0, out_valid}, 32'h0);
        adv();
        redirect_pc = 32'hbfc0_0380;
        flush       = 1'b1;
        cyc(1);

        // data_ok in the flush cycle: only the other response remains to drop.
        mem_hold     = 1'b1;
        inst_addr_ok = 1'b1;
        pc           = 32'hbfc0_0400;
        redirect_pc  = 32'hbfc0_0500;
        cyc(1);
        sample();
        mem_hold = 1'b0;
        adv();
        flush = 1'b1;
        sample();
        check("flush_data_req", {31'h0, inst_req}, 32'h0);
        check("flush_data_valid", {31'h0, out_valid}, 32'h0);
        adv();
        sample();
        check("drop_m1_req", {31'h0, inst_req}, 32'h0);
        adv();
        expect_entry(32'hbfc0_0500, 32'h3c08_0141, 1'b0);
        sample();
        check("drop_m1_resume", {31'h0, inst_req}, 32'h1);
        check("drop_m1_addr", inst_addr, 32'hbfc0_0500);
        check("drop_m1_valid", {31'h0, out_valid}, 32'h0);
        adv();
        inst_addr_ok = 1'b0;
        drain("flush_data");

        // Reset mid-stream with entries buffered.
        out_ready    = 1'b0;
        inst_addr_ok = 1'b1;
        pc           = 32'hbfc0_0600;
        cyc(3);
        resetn       = 1'b0;
        inst_addr_ok = 1'b0;
        mem_q.delete();
        inst_data_ok = 1'b0;
        sample();
        check("mid_rst_req", {31'h0, inst_req}, 32'h0);
        check("mid_rst_pc_adv", {31'h0, pc_adv}, 32'h0);
        adv();
        resetn = 1'b1;
        pc     = 32'hbfc0_0000;
        sample();
        check("post_rst_valid", {31'h0, out_valid}, 32'h0);
        check("post_rst_inst", out_inst, 32'h0);
        check("post_rst_pc", out_pc, 32'h0);
        check("post_rst_adel", {31'h0, out_adel}, 32'h0);
        adv();
        check("final_sb_empty", sb.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
